// File: rtl/column_rx_pkg.sv
// column_rx_pkg: arbiter word field positions, receiver FSM encoding and TOA Gray decoder
package column_rx_pkg;
  localparam int TOA_MSB  = 25;
  localparam int TOA_LSB  = 17;
  localparam int FTOA_MSB = 16;
  localparam int FTOA_LSB = 12;
  localparam int TOT_MSB  = 11;
  localparam int TOT_LSB  = 4;
  localparam int ADDR_MSB = 3;
  typedef enum logic [1:0] {IDLE, GRANT, CAPTURE, RELEASE} rx_state_t;
  function automatic logic [8:0] gray2bin(input logic [8:0] g);
    logic [8:0] b;
    b[8] = g[8];
    for (int i = 7; i >= 0; i--) b[i] = b[i + 1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/hit_fifo_fwft.sv
// hit_fifo_fwft: first-word-fall-through FIFO with a full flag registered from occupancy
module hit_fifo_fwft #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 8
) (
  input  logic             clk_40MHz,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic take;
  assign valid = count != '0;
  assign take = pop && valid;
  assign dout = mem[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(take);
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (take) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= count_nxt == CW'(DEPTH);
    end
  end
  // a push while full only happens alongside a pop, so overwriting the head slot is safe
  always_ff @(posedge clk_40MHz) if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/column_readout_rx.sv
// column_readout_rx: column-end shake-hands responder with TOA Gray decode and buffered hit stream
module column_readout_rx
  import column_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int COL_ID_W    = 5,
  parameter int REL_TIMEOUT = 15
) (
  input  logic                clk_40MHz,
  input  logic                rst_n,
  input  logic [COL_ID_W-1:0] col_id,
  input  logic                shake_hands_last,
  input  logic [25:0]         arbiter_data,
  output logic                shake_hands_next,
  output logic [31:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                fifo_full,
  output logic                proto_err,
  output logic [15:0]         hit_count
);
  localparam int TW = $clog2(REL_TIMEOUT + 1);
  rx_state_t state, state_nxt;
  logic [TW-1:0] rel_cnt;
  logic push, timeout;
  logic [25:0] hit_word, head;
  assign hit_word = {arbiter_data[ADDR_MSB:0], gray2bin(arbiter_data[TOA_MSB:TOA_LSB]),
                     arbiter_data[FTOA_MSB:FTOA_LSB], arbiter_data[TOT_MSB:TOT_LSB]};
  assign timeout = state == RELEASE && shake_hands_last && rel_cnt == TW'(REL_TIMEOUT - 1);
  assign out_data = out_valid ? 32'({col_id, head}) : '0;
  always_comb begin
    state_nxt = state;
    shake_hands_next = state == GRANT;
    push = state == CAPTURE;
    case (state)
      IDLE:    state_nxt = shake_hands_last && !fifo_full ? GRANT : IDLE;
      GRANT:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RELEASE;
      RELEASE: state_nxt = !shake_hands_last || timeout ? IDLE : RELEASE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      state     <= IDLE;
      rel_cnt   <= '0;
      proto_err <= 1'b0;
      hit_count <= '0;
    end else begin
      state   <= state_nxt;
      rel_cnt <= state == RELEASE ? rel_cnt + TW'(1) : '0;
      if (timeout) proto_err <= 1'b1;
      if (push && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
    end
  end
  hit_fifo_fwft #(.WIDTH(26), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_40MHz(clk_40MHz),
    .rst_n(rst_n),
    .push(push),
    .pop(out_ready),
    .din(hit_word),
    .dout(head),
    .valid(out_valid),
    .full(fifo_full)
  );
endmodule

// File: tb/tb_column_readout_rx.sv
// tb_column_readout_rx: randomized scenario bench for the column receiver against a queue model
module tb_column_readout_rx;
  localparam int DEPTH = 8;
  localparam logic [4:0] COL = 5'd19;
  logic clk_40MHz = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] col_id = COL;
  logic shake_hands_last = 1'b0;
  logic [25:0] arbiter_data = '0;
  logic out_ready = 1'b0;
  logic shake_hands_next, out_valid, fifo_full, proto_err;
  logic [31:0] out_data;
  logic [15:0] hit_count;
  logic f_push = 1'b0, f_pop = 1'b0;
  logic [31:0] f_din = '0;
  logic [31:0] f_dout;
  logic f_valid, f_full;
  int checks = 0, errors = 0, grant_cnt = 0, exp_hits = 0;
  logic v_cap, v_rel;
  logic [31:0] got_q[$], exp_q[$];

  column_readout_rx #(.FIFO_DEPTH(DEPTH), .COL_ID_W(5), .REL_TIMEOUT(15)) dut (
    .clk_40MHz(clk_40MHz), .rst_n(rst_n), .col_id(col_id),
    .shake_hands_last(shake_hands_last), .arbiter_data(arbiter_data),
    .shake_hands_next(shake_hands_next), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_full(fifo_full), .proto_err(proto_err), .hit_count(hit_count)
  );

  hit_fifo_fwft #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk_40MHz(clk_40MHz), .rst_n(rst_n), .push(f_push), .pop(f_pop), .din(f_din),
    .dout(f_dout), .valid(f_valid), .full(f_full)
  );

  always #5 clk_40MHz = ~clk_40MHz;

  always @(negedge clk_40MHz) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
    if (shake_hands_next) grant_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] mk_data(input int toa, input int ftoa, input int tot, input int addr);
    int g = toa ^ (toa >> 1);
    return 26'((g << 17) | (ftoa << 12) | (tot << 4) | addr);
  endfunction

  function automatic logic [31:0] exp_word(input int toa, input int ftoa, input int tot, input int addr);
    return (32'(COL) << 26) | 32'((addr << 22) | (toa << 13) | (ftoa << 8) | tot);
  endfunction

  // chain-side handshake: request, wait for grant, drop in CAPTURE, return once back in IDLE
  task automatic do_hit(input logic [25:0] d, output bit ok);
    int n = 0;
    ok = 1'b0;
    shake_hands_last = 1'b1;
    arbiter_data = d;
    while (!ok && n < 40) begin
      @(negedge clk_40MHz);
      ok = shake_hands_next;
      n++;
    end
    @(posedge clk_40MHz); #1;
    shake_hands_last = 1'b0;
    @(negedge clk_40MHz); v_cap = out_valid;
    @(negedge clk_40MHz); v_rel = out_valid;
    @(posedge clk_40MHz); #1;
  endtask

  task automatic send(input int toa, output bit ok);
    int ftoa = int'($urandom_range(0, 31));
    int tot = int'($urandom_range(0, 255));
    int addr = int'($urandom_range(0, 15));
    do_hit(mk_data(toa, ftoa, tot, addr), ok);
    if (ok) begin
      exp_q.push_back(exp_word(toa, ftoa, tot, addr));
      exp_hits++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk_40MHz);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk_40MHz);
    @(negedge clk_40MHz);
    checks++; if (shake_hands_next !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", shake_hands_next); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", fifo_full); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", proto_err); end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", hit_count); end
    @(posedge clk_40MHz); #1;
    rst_n = 1'b1;
    exp_hits = 0;
    @(posedge clk_40MHz); #1;
  endtask

  task automatic test_single_hit;
    bit ok;
    int g0 = grant_cnt;
    out_ready = 1'b0;
    got_q.delete(); exp_q.delete();
    do_hit(mk_data(255, 7, 49, 0), ok);
    if (ok) exp_hits++;
    checks++; if (!ok) begin errors++; $display("FAIL single_grant got none want grant"); end
    checks++; if (grant_cnt - g0 != 1) begin errors++; $display("FAIL single_pulse got %0d want 1", grant_cnt - g0); end
    checks++; if (v_cap !== 1'b0) begin errors++; $display("FAIL single_valid_capture got %b want 0", v_cap); end
    checks++; if (v_rel !== 1'b1) begin errors++; $display("FAIL single_valid_release got %b want 1", v_rel); end
    @(negedge clk_40MHz);
    checks++; if (out_data !== exp_word(255, 7, 49, 0)) begin errors++; $display("FAIL single_word got %h want %h", out_data, exp_word(255, 7, 49, 0)); end
    checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", hit_count); end
    @(posedge clk_40MHz); #1;
    drain;
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL single_popped got %0d want 1", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_gray_sweep;
    bit ok;
    out_ready = 1'b1;
    got_q.delete(); exp_q.delete();
    for (int b = 0; b <= 512; b++) begin
      send(b % 512, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sweep_grant idx %0d got none want grant", b); end
    end
    drain;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL sweep_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL sweep_word idx %0d got %h want %h", i, i < got_q.size() ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    checks++; if (hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL sweep_hits got %0d want %0d", hit_count, exp_hits); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_pressure;
    bit ok;
    int g0, n;
    int ftoa = int'($urandom_range(0, 31));
    int tot = int'($urandom_range(0, 255));
    int toa = int'($urandom_range(0, 511));
    out_ready = 1'b0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      send(int'($urandom_range(0, 511)), ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_fill_grant idx %0d got none want grant", i); end
    end
    @(negedge clk_40MHz);
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL bp_full got %b want 1", fifo_full); end
    @(posedge clk_40MHz); #1;
    g0 = grant_cnt;
    shake_hands_last = 1'b1;
    arbiter_data = mk_data(toa, ftoa, tot, 9);
    repeat (10) @(negedge clk_40MHz);
    checks++; if (grant_cnt != g0) begin errors++; $display("FAIL bp_grant_while_full got %0d want 0", grant_cnt - g0); end
    @(posedge clk_40MHz); #1;
    out_ready = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 20) begin
      @(negedge clk_40MHz);
      ok = shake_hands_next;
      n++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL bp_late_grant got none want grant"); end
    checks++; if (got_q.size() < 1) begin errors++; $display("FAIL bp_grant_before_pop got %0d pops want >=1", got_q.size()); end
    @(posedge clk_40MHz); #1;
    shake_hands_last = 1'b0;
    exp_q.push_back(exp_word(toa, ftoa, tot, 9));
    exp_hits++;
    drain;
    checks++; if (got_q.size() != DEPTH + 1) begin errors++; $display("FAIL bp_count got %0d want %0d", got_q.size(), DEPTH + 1); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_word idx %0d got %h want %h", i, i < got_q.size() ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    checks++; if (hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL bp_hits got %0d want %0d", hit_count, exp_hits); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_stuck_request;
    bit ok = 1'b0;
    int n = 0;
    out_ready = 1'b1;
    got_q.delete();
    shake_hands_last = 1'b1;
    arbiter_data = mk_data(int'($urandom_range(0, 511)), 3, 4, 5);
    while (!ok && n < 10) begin
      @(negedge clk_40MHz);
      ok = shake_hands_next;
      n++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL stuck_grant got none want grant"); end
    repeat (15) @(negedge clk_40MHz);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL stuck_err_early14 got %b want 0", proto_err); end
    @(negedge clk_40MHz);
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL stuck_err_early15 got %b want 0", proto_err); end
    @(negedge clk_40MHz);
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL stuck_err_set got %b want 1", proto_err); end
    checks++; if (shake_hands_next !== 1'b0) begin errors++; $display("FAIL stuck_idle_grant got %b want 0", shake_hands_next); end
    @(negedge clk_40MHz);
    checks++; if (shake_hands_next !== 1'b1) begin errors++; $display("FAIL stuck_regrant got %b want 1", shake_hands_next); end
    @(posedge clk_40MHz); #1;
    shake_hands_last = 1'b0;
    repeat (4) @(posedge clk_40MHz);
    #1;
    exp_hits += 2;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL stuck_err_sticky got %b want 1", proto_err); end
    checks++; if (hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL stuck_hits got %0d want %0d", hit_count, exp_hits); end
    drain;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL stuck_words got %0d want 2", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_reset_mid;
    bit ok = 1'b0;
    int n = 0;
    out_ready = 1'b1;
    got_q.delete();
    shake_hands_last = 1'b1;
    arbiter_data = mk_data(int'($urandom_range(0, 511)), 1, 2, 3);
    while (!ok && n < 10) begin
      @(negedge clk_40MHz);
      ok = shake_hands_next;
      n++;
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_grant got none want grant"); end
    @(posedge clk_40MHz); #1;
    rst_n = 1'b0;
    shake_hands_last = 1'b0;
    @(posedge clk_40MHz); #1;
    rst_n = 1'b1;
    exp_hits = 0;
    @(negedge clk_40MHz);
    checks++; if (shake_hands_next !== 1'b0) begin errors++; $display("FAIL rstmid_grant_after got %b want 0", shake_hands_next); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rstmid_hits got %0d want 0", hit_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", proto_err); end
    repeat (4) @(posedge clk_40MHz);
    #1;
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rstmid_words got %0d want 0", got_q.size()); end
  endtask

  task automatic test_random;
    bit ok;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 60; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (fifo_full) out_ready = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk_40MHz); #1;
      end
      send(int'($urandom_range(0, 511)), ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_grant idx %0d got none want grant", i); end
    end
    drain;
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_word idx %0d got %h want %h", i, i < got_q.size() ? got_q[i] : 32'hx, exp_q[i]);
      end
    end
    checks++; if (hit_count !== 16'(exp_hits)) begin errors++; $display("FAIL rand_hits got %0d want %0d", hit_count, exp_hits); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_fifo_full_push_pop;
    logic [31:0] fq[$];
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      f_push = 1'b1;
      f_din = v;
      fq.push_back(v);
      @(posedge clk_40MHz); #1;
    end
    f_push = 1'b0;
    @(negedge clk_40MHz);
    checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL ff_full got %b want 1", f_full); end
    @(posedge clk_40MHz); #1;
    for (int i = 0; i < 5; i++) begin
      v = $urandom;
      f_push = 1'b1;
      f_pop = 1'b1;
      f_din = v;
      @(negedge clk_40MHz);
      checks++; if (f_dout !== fq[0]) begin errors++; $display("FAIL ff_pushpop_head idx %0d got %h want %h", i, f_dout, fq[0]); end
      checks++; if (f_full !== 1'b1) begin errors++; $display("FAIL ff_pushpop_full idx %0d got %b want 1", i, f_full); end
      @(posedge clk_40MHz); #1;
      void'(fq.pop_front());
      fq.push_back(v);
    end
    f_push = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk_40MHz);
      checks++; if (f_valid !== 1'b1 || f_dout !== fq[0]) begin errors++; $display("FAIL ff_drain idx %0d got %b/%h want 1/%h", i, f_valid, f_dout, fq[0]); end
      @(posedge clk_40MHz); #1;
      void'(fq.pop_front());
    end
    f_pop = 1'b0;
    @(negedge clk_40MHz);
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL ff_empty got %b want 0", f_valid); end
  endtask

  initial begin
    test_reset;
    test_single_hit;
    test_gray_sweep;
    test_back_pressure;
    test_stuck_request;
    test_reset_mid;
    test_random;
    test_fifo_full_push_pop;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
